ps2_device_tx_fifo: RTL and testbench
=====================================

Name: ps2_device_tx_fifo

Overview:
Parametrised PS/2 device-side transmitter that replaces the single-shot keyboard model in DESim simulations. It buffers scan-code bytes from key_action/scan_code pulses in a FIFO and serialises each byte as a PS/2 frame on ps2_clk/ps2_dat: start bit, 8 data bits LSB first, odd parity, stop bit. Adds multi-byte buffering, a programmable bit rate, an inter-frame gap, host-inhibit handling with retransmit, and overflow status.

Parameters:
CLK_DIV, 2000, CLOCK_50 cycles per ps2_clk half-period (≥2); 2000 gives 12.5 kHz.
GAP_CYCLES, 4000, minimum idle cycles (clk=1, dat=1) after each completed or aborted frame (≥1).
FIFO_DEPTH, 16, byte entries; power of 2, ≥2.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
key_action  input  1  one-cycle push strobe.
scan_code  input  8  byte pushed when key_action=1.
inhibit  input  1  host holding the PS/2 clock low; blocks and aborts transmission.
ps2_clk  output  1  PS/2 clock, driven by the device.
ps2_dat  output  1  PS/2 data, driven by the device.
busy  output  1  a frame or gap is in progress.
count  output  $clog2(FIFO_DEPTH+1)  bytes held in the FIFO.
full  output  1  count==FIFO_DEPTH.
overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (synchronous, highest priority, any state, including mid-frame):
  - ps2_clk=1, ps2_dat=1, busy=0, count=0, full=0, overflow=0.
  - FIFO emptied; state=IDLE.
- FIFO push:
  - key_action=1 and not full: write scan_code at the tail; count+1 on the next edge.
  - key_action=1 and full: byte dropped, overflow←1 and held until reset.
- FIFO pop:
  - Happens only when a frame completes. The head byte is peeked at frame start and is not removed on abort.
  - Push and pop on the same cycle: count unchanged; no overflow even when full.
- States: IDLE, BIT_HI, BIT_LO, GAP. A bit index 0..10 and a CLK_DIV half-period counter are kept.
- IDLE:
  - ps2_clk=1, ps2_dat=1, busy=0.
  - If count>0 and inhibit=0: latch the head byte, compute frame = {1, ~^byte, byte, 0}, set index=0, go to BIT_HI.
  - Latency from empty FIFO: key_action sampled at edge N → count=1 at edge N+1 → ps2_dat=0 (start bit) and busy=1 at edge N+2.
- BIT_HI:
  - ps2_dat=frame[index], ps2_clk=1 for CLK_DIV cycles, then go to BIT_LO.
  - Data changes only while ps2_clk is high.
- BIT_LO:
  - ps2_clk=0 for CLK_DIV cycles; ps2_dat held.
  - Then if index<10: index+1, go to BIT_HI.
  - If index==10: pop the FIFO and go to GAP.
- Full frame: 11 bits × 2·CLK_DIV cycles = 22·CLK_DIV cycles of low/high clock activity.
- GAP:
  - ps2_clk=1, ps2_dat=1, busy=1 for GAP_CYCLES cycles, then go to IDLE.
  - Back-to-back bytes are therefore separated by at least GAP_CYCLES+1 cycles of idle lines.
- Inhibit:
  - In BIT_HI or BIT_LO with index≤9, inhibit=1 aborts the frame on the next edge: ps2_clk=1, ps2_dat=1, byte not popped, go to GAP.
  - The GAP counter does not advance while inhibit=1, so retransmission starts no earlier than GAP_CYCLES cycles after inhibit falls.
  - Inhibit during index 10 (stop bit) or during GAP does not abort; the frame counts as delivered.
- Parity is odd: the count of 1s across data plus parity is odd.
- count never exceeds FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- CLK_DIV=4, GAP_CYCLES=8; key_action with 0x1C at edge N → ps2_dat low at N+2; values sampled on ps2_clk falling edges are 0,0,0,1,1,1,0,0,0,0(parity),1; busy falls 88+8 cycles after the start bit; count back to 0.
- Same settings; 0xF0 and 0x1C pushed on consecutive cycles → count=2; two frames with parity bits 1 then 0; ps2_clk stays high ≥8 cycles between frames.
- FIFO_DEPTH=4, inhibit=1; six pushes 0x01..0x06 → count=4, full=1, overflow=1; release inhibit → only 0x01..0x04 transmitted; overflow still 1.
- Inhibit pulsed during data bit 3 of 0x5A → lines go high next cycle, count stays 1; after inhibit falls, full 0x5A frame resent once, then count=0.
- Inhibit asserted during stop bit → no abort; byte popped; no retransmit.
- Reset asserted mid-frame (bit 5) → next cycle ps2_clk=1, ps2_dat=1, busy=0, count=0, overflow=0; no further clock activity.

Source files
------------

// File: rtl/ps2_device_tx_fifo.sv
// PS/2 device-side transmitter fed by a byte FIFO.
// Frames are start, 8 data bits LSB first, odd parity and stop. Host inhibit aborts a frame, which is then retransmitted.
module ps2_device_tx_fifo #(
   parameter int CLK_DIV    = 2000,
   parameter int GAP_CYCLES = 4000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                              CLOCK_50,
   input  logic                              reset,
   input  logic                              key_action,
   input  logic [7:0]                        scan_code,
   input  logic                              inhibit,
   output logic                              ps2_clk,
   output logic                              ps2_dat,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic                              full,
   output logic                              overflow
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BIT_HI = 2'd1,
      BIT_LO = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t          state_q;
   logic [3:0]      idx_q;
   logic [DW-1:0]   div_q;
   logic [GW-1:0]   gap_q;
   logic [10:0]     frame_q;
   logic            clk_q, dat_q, busy_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d, ovf_q, ovf_d;

   logic [7:0]      head_s;
   logic            div_done_s, abort_s, pop_s, push_s;

   assign head_s     = mem_q[rd_q];
   assign div_done_s = (div_q == DW'(CLK_DIV - 1));
   assign abort_s    = inhibit && ((state_q == BIT_HI) || (state_q == BIT_LO)) && (idx_q <= 4'd9);
   assign pop_s      = (state_q == BIT_LO) && div_done_s && (idx_q == 4'd10);
   // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
   assign push_s     = key_action && (!full_q || pop_s);

   assign ps2_clk  = clk_q;
   assign ps2_dat  = dat_q;
   assign busy     = busy_q;
   assign count    = count_q;
   assign full     = full_q;
   assign overflow = ovf_q;

   // FIFO pointer, occupancy and overflow next-state
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      ovf_d   = ovf_q | (key_action && full_q && !pop_s);
      if (push_s) begin
         wr_d = wr_q + AW'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + AW'(1);
      end else begin
         rd_d = rd_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CW'(FIFO_DEPTH));
   end

   // FIFO control registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   // FIFO storage
   always_ff @(posedge CLOCK_50) begin
      if (push_s) begin
         mem_q[wr_q] <= scan_code;
      end
   end

   // Frame serialiser with registered line outputs
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         div_q   <= '0;
         gap_q   <= '0;
         frame_q <= 11'h7FF;
         clk_q   <= 1'b1;
         dat_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if ((count_q != CW'(0)) && !inhibit) begin
                  frame_q <= {1'b1, ~^head_s, head_s, 1'b0};
                  idx_q   <= 4'd0;
                  div_q   <= '0;
                  clk_q   <= 1'b1;
                  dat_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= BIT_HI;
               end else begin
                  clk_q  <= 1'b1;
                  dat_q  <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            BIT_HI: begin
               if (abort_s) begin
                  clk_q   <= 1'b1;
                  dat_q   <= 1'b1;
                  gap_q   <= '0;
                  state_q <= GAP;
               end else if (div_done_s) begin
                  div_q   <= '0;
                  clk_q   <= 1'b0;
                  state_q <= BIT_LO;
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            BIT_LO: begin
               if (abort_s) begin
                  clk_q   <= 1'b1;
                  dat_q   <= 1'b1;
                  gap_q   <= '0;
                  state_q <= GAP;
               end else if (div_done_s) begin
                  div_q <= '0;
                  clk_q <= 1'b1;
                  if (idx_q < 4'd10) begin
                     idx_q   <= idx_q + 4'd1;
                     dat_q   <= frame_q[idx_q + 4'd1];
                     state_q <= BIT_HI;
                  end else begin
                     dat_q   <= 1'b1;
                     gap_q   <= '0;
                     state_q <= GAP;
                  end
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            GAP: begin
               // The gap is frozen while the host inhibits.
               if (!inhibit) begin
                  if (gap_q == GW'(GAP_CYCLES - 1)) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     gap_q <= gap_q + GW'(1);
                  end
               end else begin
                  gap_q <= gap_q;
               end
            end
            default: begin
               clk_q   <= 1'b1;
               dat_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_device_tx_fifo.sv
// Directed bench for ps2_device_tx_fifo: a line monitor decodes frames and checks them against a byte scoreboard.
module tb_ps2_device_tx_fifo;

   localparam int CLK_DIV    = 4;
   localparam int GAP_CYCLES = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int CW         = $clog2(FIFO_DEPTH + 1);

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b1;
   logic          key_action = 1'b0;
   logic [7:0]    scan_code = 8'h00;
   logic          inhibit = 1'b0;
   logic          ps2_clk, ps2_dat, busy, full, overflow;
   logic [CW-1:0] count;

   int            tests = 0;
   int            fails = 0;

   logic [7:0]    exp_q[$];
   int            frames = 0;
   int            falls = 0;
   int            gap_seen = 0;
   logic [10:0]   last_frame = 11'h000;

   ps2_device_tx_fifo #(
      .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .key_action(key_action), .scan_code(scan_code),
      .inhibit(inhibit), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .busy(busy),
      .count(count), .full(full), .overflow(overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b, input bit accepted);
      key_action = 1'b1;
      scan_code  = b;
      if (accepted) exp_q.push_back(b);
      step(1);
      key_action = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while ((busy || count != '0) && n < limit) begin
         step(1);
         n++;
      end
      check(tag, 32'(n < limit), 32'd1);
   endtask

   task automatic wait_start(input string tag, input int limit);
      int n = 0;
      while (!busy && n < limit) begin
         step(1);
         n++;
      end
      check(tag, 32'(n < limit), 32'd1);
   endtask

   // Line monitor: samples data on each ps2_clk falling edge and scores complete frames.
   initial begin
      logic        prev_clk = 1'b1;
      int          nbits = 0;
      int          hi_run = 0;
      logic [10:0] sh = 11'h000;
      logic [7:0]  b;
      forever begin
         @(negedge CLOCK_50);
         if (prev_clk && !ps2_clk) begin
            falls++;
            if (nbits == 0) gap_seen = hi_run;
            sh[nbits] = ps2_dat;
            nbits++;
            if (nbits == 11) begin
               nbits = 0;
               frames++;
               last_frame = sh;
               check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  b = exp_q.pop_front();
                  check("start_bit", 32'(sh[0]), 32'd0);
                  check("data_byte", 32'(sh[8:1]), 32'(b));
                  check("odd_parity", 32'(sh[9]), 32'(($countones(b) % 2) == 0));
                  check("stop_bit", 32'(sh[10]), 32'd1);
               end
            end
         end
         if (ps2_clk) hi_run++;
         else hi_run = 0;
         if (hi_run > CLK_DIV + 1) nbits = 0;
         prev_clk = ps2_clk;
      end
   end

   initial begin
      int n;
      int f0;

      // Reset state
      step(2);
      reset = 1'b0;
      check("rst_clk", 32'(ps2_clk), 32'd1);
      check("rst_dat", 32'(ps2_dat), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      step(3);

      // Single byte 0x1C: latency, exact bit pattern, frame+gap length
      push(8'h1C, 1'b1);
      check("lat_count", 32'(count), 32'd1);
      check("lat_idle_dat", 32'(ps2_dat), 32'd1);
      step(1);
      check("start_dat", 32'(ps2_dat), 32'd0);
      check("start_busy", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 200) begin
         step(1);
         n++;
      end
      check("busy_len", 32'(n), 32'(22 * CLK_DIV + GAP_CYCLES));
      check("pattern_1c", 32'(last_frame), 32'({1'b1, 1'b0, 8'h1C, 1'b0}));
      check("count_after_1c", 32'(count), 32'd0);
      step(5);

      // Back-to-back 0xF0, 0x1C
      push(8'hF0, 1'b1);
      push(8'h1C, 1'b1);
      check("count_two", 32'(count), 32'd2);
      wait_done("to_b2b", 600);
      check("parity_1c_last", 32'(last_frame[9]), 32'd0);
      check("gap_between", 32'(gap_seen >= GAP_CYCLES + 1 + CLK_DIV), 32'd1);
      check("sb_empty_b2b", 32'(exp_q.size()), 32'd0);
      step(5);

      // Overflow while inhibited
      inhibit = 1'b1;
      step(2);
      for (int i = 1; i <= 6; i++) push(8'(i), i <= FIFO_DEPTH);
      step(3);
      check("ovf_count", 32'(count), 32'(FIFO_DEPTH));
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("inh_idle", 32'(busy), 32'd0);
      f0 = frames;
      inhibit = 1'b0;
      wait_done("to_drain", 2000);
      check("drain_frames", 32'(frames - f0), 32'(FIFO_DEPTH));
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("drain_full", 32'(full), 32'd0);
      step(5);

      // Abort during data bit 3 of 0x5A, then retransmit
      f0 = frames;
      push(8'h5A, 1'b1);
      wait_start("to_5a", 20);
      step(8 * 4 + 2);
      inhibit = 1'b1;
      step(1);
      inhibit = 1'b0;
      check("abort_clk", 32'(ps2_clk), 32'd1);
      check("abort_dat", 32'(ps2_dat), 32'd1);
      check("abort_count", 32'(count), 32'd1);
      wait_done("to_resend", 600);
      check("resend_frames", 32'(frames - f0), 32'd1);
      check("resend_count", 32'(count), 32'd0);
      step(5);

      // Inhibit during stop bit: delivered, no retransmit
      f0 = frames;
      push(8'h3C, 1'b1);
      wait_start("to_3c", 20);
      step(8 * 10 + 2);
      inhibit = 1'b1;
      step(3);
      inhibit = 1'b0;
      wait_done("to_stop_inh", 600);
      step(60);
      check("stop_inh_frames", 32'(frames - f0), 32'd1);
      check("stop_inh_count", 32'(count), 32'd0);
      check("sb_empty_stop", 32'(exp_q.size()), 32'd0);

      // Reset mid-frame (bit 5)
      push(8'h77, 1'b1);
      push(8'h11, 1'b1);
      wait_start("to_77", 20);
      step(8 * 6 + 2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      exp_q.delete();
      check("mid_rst_clk", 32'(ps2_clk), 32'd1);
      check("mid_rst_dat", 32'(ps2_dat), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      f0 = falls;
      step(150);
      check("quiet_after_rst", 32'(falls - f0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
